// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the two-master processor-side device bus arbiter.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BYTEEN_READ = 4'b0000;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way fixed-priority pick: with both requests active, the prio master wins.
module rr_pick2
  import dev_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = (prio == MST_M1) ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing the bridge between the CPU data port (m0) and DMA/debug port (m1),
// with bounded locked bursts and a one-cycle registered read-return tag.
module dev_bus_arbiter
  import dev_bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_byteen,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_byteen,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] pr_addr,
  output logic [DATA_W-1:0] pr_wdata,
  output logic [3:0]        pr_byteen,
  input  logic [DATA_W-1:0] pr_rdata,
  output state_t            state
);

  // Handshake: a master holds req (and its addr/wdata/byteen/lock) until it sees gnt, which is
  // combinational in the same cycle; a granted read returns on rvalid exactly one cycle later.
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             rtag_v_q, rtag_v_d;
  logic             rtag_idx_q, rtag_idx_d;

  logic [1:0]       pick;
  logic [1:0]       gnt;
  logic             gnt_idx;
  logic             gnt_lock;
  logic [3:0]       gnt_byteen;
  logic [CNT_W-1:0] beat_next;

  rr_pick2 u_pick (
    .req  ({m1_req, m0_req}),
    .prio (prio_q),
    .gnt  (pick)
  );

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    beat_d     = beat_q;
    gnt        = 2'b00;
    case (state_q)
      ST_IDLE: gnt = pick;
      ST_OWN0: gnt = {1'b0, m0_req};
      ST_OWN1: gnt = {m1_req, 1'b0};
      default: gnt = 2'b00;
    endcase
    if (reset) begin
      gnt = 2'b00;
    end

    gnt_idx    = gnt[1];
    gnt_lock   = gnt_idx ? m1_lock : m0_lock;
    gnt_byteen = gnt_idx ? m1_byteen : m0_byteen;
    beat_next  = (state_q == ST_IDLE) ? CNT_ONE : beat_q + CNT_ONE;

    if (gnt != 2'b00) begin
      if (state_q == ST_IDLE) begin
        prio_d = ~gnt_idx;
      end
      // The MAX_BURST-th consecutive grant always ends ownership, whatever lock says.
      if (beat_next == CNT_MAX) begin
        prio_d  = ~gnt_idx;
        state_d = ST_IDLE;
        beat_d  = '0;
      end else if (gnt_lock) begin
        state_d = gnt_idx ? ST_OWN1 : ST_OWN0;
        beat_d  = beat_next;
      end else begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    end else begin
      state_d = ST_IDLE;
      beat_d  = '0;
    end

    rtag_v_d   = (gnt != 2'b00) && (gnt_byteen == BYTEEN_READ);
    rtag_idx_d = gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prio_q     <= MST_M0;
      beat_q     <= '0;
      rtag_v_q   <= 1'b0;
      rtag_idx_q <= MST_M0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      beat_q     <= beat_d;
      rtag_v_q   <= rtag_v_d;
      rtag_idx_q <= rtag_idx_d;
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign pr_addr   = gnt[0] ? m0_addr   : (gnt[1] ? m1_addr   : '0);
  assign pr_wdata  = gnt[0] ? m0_wdata  : (gnt[1] ? m1_wdata  : '0);
  assign pr_byteen = gnt[0] ? m0_byteen : (gnt[1] ? m1_byteen : 4'b0000);

  // Reset also masks a read return still in flight from the cycle before.
  assign m0_rvalid = rtag_v_q && (rtag_idx_q == MST_M0) && !reset;
  assign m1_rvalid = rtag_v_q && (rtag_idx_q == MST_M1) && !reset;
  assign m0_rdata  = m0_rvalid ? pr_rdata : '0;
  assign m1_rdata  = m1_rvalid ? pr_rdata : '0;
  assign state     = state_q;

endmodule
